// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX among NUM_REQ byte producers.
// Accepts one byte per handshake from the winner, launches it with a one-cycle
// Data_Valid strobe, follows the transmitter's busy through the frame, then
// optionally waits GAP_CYCLES idle cycles before the next grant.
//
// Ports:
//   CLK, RST                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_data        per-requester byte pending, byte i at [8i+7:8i]
//   req_par_en/req_par_type   per-requester parity settings
//   req_ready                 one-hot, one-cycle acceptance pulse
//   P_DATA, Data_Valid,
//   parity_enable, parity_type  drive the UART TX inputs
//   busy                      UART TX busy output
//   grant_id                  index of current/last granted requester
//   active                    high from launch until frame and gap complete
//   timeout_err, err_clr      sticky busy-never-rose flag and its clear
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_par_en,
  input  logic [NUM_REQ-1:0]         req_par_type,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 P_DATA,
  output logic                       Data_Valid,
  output logic                       parity_enable,
  output logic                       parity_type,
  input  logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam int unsigned SW       = IDW + 1;
  localparam int unsigned TW       = 8;
  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [7:0]         pdata_q, pdata_d;
  logic               par_en_q, par_en_d;
  logic               par_type_q, par_type_d;
  logic               dv_q, dv_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               active_q, active_d;
  logic               err_q, err_d;
  logic               err_set;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

  logic [IDW-1:0]     winner;
  logic               found;
  logic [SW-1:0]      scan_idx;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    winner   = rr_ptr_q;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = SW'(rr_ptr_q) + SW'(i);
      if (scan_idx >= SW'(NUM_REQ)) begin
        scan_idx = scan_idx - SW'(NUM_REQ);
      end
      if (!found && req_valid[scan_idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IDW-1:0];
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    pdata_d    = pdata_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_set    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found && !busy) begin
          state_d    = S_LAUNCH;
          grant_id_d = winner;
          pdata_d    = req_data[{winner, 3'b000} +: 8];
          par_en_d   = req_par_en[winner];
          par_type_d = req_par_type[winner];
          rr_ptr_d   = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
        end
      end
      S_LAUNCH: begin
        state_d  = S_WAIT_START;
        to_cnt_d = '0;
      end
      S_WAIT_START: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
          // Transmitter never started: drop the byte and flag it.
          if (to_cnt_d == TW'(BUSY_TIMEOUT)) begin
            err_set   = 1'b1;
            state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            gap_cnt_d = '0;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Set has priority over a coincident clear.
    err_d    = err_set | (err_q & ~err_clr);
    // Strobes are registered off the next state so they align with LAUNCH.
    dv_d     = (state_d == S_LAUNCH);
    ready_d  = dv_d ? (NUM_REQ'(1) << grant_id_d) : '0;
    active_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      pdata_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      dv_q       <= 1'b0;
      ready_q    <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      pdata_q    <= pdata_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      dv_q       <= dv_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign req_ready     = ready_q;
  assign P_DATA        = pdata_q;
  assign Data_Valid    = dv_q;
  assign parity_enable = par_en_q;
  assign parity_type   = par_type_q;
  assign grant_id      = grant_id_q;
  assign active        = active_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       pt;
  } item_t;

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  pe;
    logic [3:0]  pt;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_pdata;
    logic        exp_pe;
    logic        exp_pt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_pe;
  logic [3:0]  req_pt;
  logic [3:0]  req_ready;
  logic [7:0]  P_DATA;
  logic        Data_Valid;
  logic        parity_enable;
  logic        parity_type;
  logic        busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;
  logic        err_clr;

  logic        g_valid_dummy;
  logic [3:0]  g_valid;
  logic [3:0]  g_ready;
  logic [7:0]  g_pdata;
  logic        g_dv;
  logic        g_pe;
  logic        g_pt;
  logic        g_busy;
  logic [1:0]  g_gid;
  logic        g_active;
  logic        g_err;

  // Simple UART TX stand-in: busy rises after Data_Valid and lasts frame_len cycles.
  logic        busy_mode;
  logic        busy_force;
  logic        busy_m = 1'b0;
  int          fcnt = 0;
  int          frame_len;

  int checks = 0;
  int errors = 0;

  assign busy = busy_mode ? busy_force : busy_m;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(16)) u_dut (
    .CLK(clk), .RST(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_pe), .req_par_type(req_pt),
    .req_ready(req_ready), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .busy(busy), .grant_id(grant_id), .active(active),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .BUSY_TIMEOUT(16)) u_gap (
    .CLK(clk), .RST(rst_n),
    .req_valid(g_valid), .req_data(32'h44332211),
    .req_par_en(4'b0000), .req_par_type(4'b0000),
    .req_ready(g_ready), .P_DATA(g_pdata), .Data_Valid(g_dv),
    .parity_enable(g_pe), .parity_type(g_pt),
    .busy(g_busy), .grant_id(g_gid), .active(g_active),
    .timeout_err(g_err), .err_clr(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Data_Valid) begin
      busy_m <= 1'b1;
      fcnt   <= frame_len;
    end else if (fcnt > 1) begin
      fcnt <= fcnt - 1;
    end else begin
      fcnt   <= 0;
      busy_m <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_p_data"},      32'(P_DATA), 32'h0);
    chk({tag, "_data_valid"},  32'(Data_Valid), 32'h0);
    chk({tag, "_parity_en"},   32'(parity_enable), 32'h0);
    chk({tag, "_parity_type"}, 32'(parity_type), 32'h0);
    chk({tag, "_req_ready"},   32'(req_ready), 32'h0);
    chk({tag, "_grant_id"},    32'(grant_id), 32'h0);
    chk({tag, "_active"},      32'(active), 32'h0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", 32'(active), 32'h0);
  endtask

  // Reference arbitration: first requester at or after ptr, modulo N.
  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [3:0] exp_rdy;
    logic       early;
    int         n;
    wait_idle();
    req_valid = v.valid;
    req_data  = v.data;
    req_pe    = v.pe;
    req_pt    = v.pt;
    @(negedge clk);
    exp_rdy = 4'b0001 << v.exp_gid;
    chk("vec_dv_latency", 32'(Data_Valid), 32'h1);
    chk("vec_grant_id",   32'(grant_id), 32'(v.exp_gid));
    chk("vec_p_data",     32'(P_DATA), 32'(v.exp_pdata));
    chk("vec_parity_en",  32'(parity_enable), 32'(v.exp_pe));
    chk("vec_parity_type", 32'(parity_type), 32'(v.exp_pt));
    chk("vec_req_ready",  32'(req_ready), 32'(exp_rdy));
    chk("vec_active",     32'(active), 32'h1);
    req_valid = '0;
    @(negedge clk);
    chk("vec_dv_one_cycle",    32'(Data_Valid), 32'h0);
    chk("vec_ready_one_cycle", 32'(req_ready), 32'h0);
    early = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      if (active !== 1'b1) early = 1'b1;
      if (parity_enable !== v.exp_pe) early = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("vec_active_held_in_frame", 32'(early), 32'h0);
    wait_idle();
    chk("vec_p_data_held_idle", 32'(P_DATA), 32'(v.exp_pdata));
  endtask

  vec_t  tbl[15];
  item_t rq[N][$];
  item_t it;

  initial begin
    int exp_ptr;
    int w;
    int pushed;
    int sent;
    int cyc;
    logic prev_dv;
    logic [3:0] exp_rdy;

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_pe = '0; req_pt = '0;
    err_clr = 1'b0; busy_mode = 1'b0; busy_force = 1'b0; frame_len = 4;
    g_valid = '0; g_busy = 1'b0; g_valid_dummy = 1'b0;

    //                valid    data          pe       pt       gid    pdata  pe    pt
    tbl[0]  = '{4'b1111, 32'h44332211, 4'b1010, 4'b0110, 2'd0, 8'h11, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 32'h44332211, 4'b1010, 4'b0110, 2'd1, 8'h22, 1'b1, 1'b1};
    tbl[2]  = '{4'b1111, 32'h44332211, 4'b1010, 4'b0110, 2'd2, 8'h33, 1'b0, 1'b1};
    tbl[3]  = '{4'b1111, 32'h44332211, 4'b1010, 4'b0110, 2'd3, 8'h44, 1'b1, 1'b0};
    tbl[4]  = '{4'b1111, 32'h44332211, 4'b1010, 4'b0110, 2'd0, 8'h11, 1'b0, 1'b0};
    tbl[5]  = '{4'b1111, 32'h44332211, 4'b1010, 4'b0110, 2'd1, 8'h22, 1'b1, 1'b1};
    tbl[6]  = '{4'b1010, 32'h44332211, 4'b1010, 4'b0110, 2'd3, 8'h44, 1'b1, 1'b0};
    tbl[7]  = '{4'b1010, 32'h44332211, 4'b1010, 4'b0110, 2'd1, 8'h22, 1'b1, 1'b1};
    tbl[8]  = '{4'b1010, 32'h44332211, 4'b1010, 4'b0110, 2'd3, 8'h44, 1'b1, 1'b0};
    tbl[9]  = '{4'b1010, 32'h44332211, 4'b1010, 4'b0110, 2'd1, 8'h22, 1'b1, 1'b1};
    tbl[10] = '{4'b0100, 32'h33A52211, 4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b1};
    tbl[11] = '{4'b0001, 32'h44332211, 4'b1010, 4'b0110, 2'd0, 8'h11, 1'b0, 1'b0};
    tbl[12] = '{4'b1000, 32'h44332211, 4'b1010, 4'b0110, 2'd3, 8'h44, 1'b1, 1'b0};
    tbl[13] = '{4'b0110, 32'h44332211, 4'b1010, 4'b0110, 2'd1, 8'h22, 1'b1, 1'b1};
    tbl[14] = '{4'b0011, 32'h44332211, 4'b1010, 4'b0110, 2'd0, 8'h11, 1'b0, 1'b0};

    #1;
    check_reset("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin order, skip/wrap and single request from the table.
    for (int r = 0; r < 15; r++) run_vec(tbl[r]);

    // Back-to-back launch timing with no gap (busy driven by hand).
    busy_mode = 1'b1; busy_force = 1'b0;
    wait_idle();
    req_valid = 4'b0011; req_data = 32'h44332211; req_pe = 4'b1010; req_pt = 4'b0110;
    @(negedge clk);
    chk("g0_first_dv", 32'(Data_Valid), 32'h1);
    chk("g0_first_gid", 32'(grant_id), 32'h1);
    req_valid = 4'b0001; busy_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("g0_active_while_busy", 32'(active), 32'h1);
    chk("g0_no_dv_while_busy", 32'(Data_Valid), 32'h0);
    busy_force = 1'b0;
    @(negedge clk);
    chk("g0_no_dv_n1", 32'(Data_Valid), 32'h0);
    @(negedge clk);
    chk("g0_dv_n2", 32'(Data_Valid), 32'h1);
    chk("g0_second_gid", 32'(grant_id), 32'h0);
    req_valid = '0; busy_force = 1'b1;
    repeat (2) @(negedge clk);
    busy_force = 1'b0;
    wait_idle();

    // Same sequence on the GAP_CYCLES=3 instance.
    g_valid = 4'b0011;
    @(negedge clk);
    chk("gap_first_dv", 32'(g_dv), 32'h1);
    chk("gap_first_gid", 32'(g_gid), 32'h0);
    g_valid = 4'b0010; g_busy = 1'b1;
    repeat (3) @(negedge clk);
    g_busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("gap_no_dv_early", 32'(g_dv), 32'h0);
      chk("gap_active_in_gap", 32'(g_active), (k < 4) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    chk("gap_dv_after_gap", 32'(g_dv), 32'h1);
    chk("gap_second_gid", 32'(g_gid), 32'h1);
    chk("gap_second_data", 32'(g_pdata), 32'h22);
    g_valid = '0; g_busy = 1'b1;
    repeat (2) @(negedge clk);
    g_busy = 1'b0;

    // Busy never rises: timeout after 16 WAIT_START cycles.
    wait_idle();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("to_dv", 32'(Data_Valid), 32'h1);
    chk("to_gid", 32'(grant_id), 32'h0);
    req_valid = '0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        chk("to_err_not_yet", 32'(timeout_err), 32'h0);
        chk("to_active_waiting", 32'(active), 32'h1);
      end
      if (k == 17) begin
        chk("to_err_set", 32'(timeout_err), 32'h1);
        chk("to_back_idle", 32'(active), 32'h0);
      end
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_cleared", 32'(timeout_err), 32'h0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("to_next_served_dv", 32'(Data_Valid), 32'h1);
    chk("to_next_served_gid", 32'(grant_id), 32'h2);
    req_valid = '0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 16) err_clr = 1'b1;
      if (k == 17) begin
        err_clr = 1'b0;
        chk("to_set_beats_clear", 32'(timeout_err), 32'h1);
      end
      if (k == 18) chk("to_err_sticky", 32'(timeout_err), 32'h1);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_cleared_again", 32'(timeout_err), 32'h0);

    // Reset in the middle of a frame.
    wait_idle();
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rst_pre_dv", 32'(Data_Valid), 32'h1);
    req_valid = '0; busy_force = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pre_active", 32'(active), 32'h1);
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1001;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_hold_no_dv", 32'(Data_Valid), 32'h0);
      chk("rst_hold_no_ready", 32'(req_ready), 32'h0);
    end
    busy_force = 1'b0;
    @(negedge clk);
    chk("rst_release_dv", 32'(Data_Valid), 32'h1);
    chk("rst_release_gid", 32'(grant_id), 32'h0);
    req_valid = '0; busy_force = 1'b1;
    repeat (2) @(negedge clk);
    busy_force = 1'b0;

    // Randomized traffic against a queue-based round-robin model.
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    busy_mode = 1'b0;
    rst_n = 1'b1;
    exp_ptr = 0; pushed = 0; sent = 0; cyc = 0; prev_dv = 1'b0;
    while (sent < 80 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (Data_Valid === 1'b1) begin
        chk("rand_dv_one_cycle", 32'(prev_dv), 32'h0);
        w = rr_pick(req_valid, exp_ptr);
        if (w < 0) begin
          chk("rand_spurious_dv", 32'(req_valid), 32'h1);
        end else begin
          it = rq[w][0];
          exp_rdy = 4'b0001 << w;
          chk("rand_grant_id", 32'(grant_id), 32'(w));
          chk("rand_p_data", 32'(P_DATA), 32'(it.data));
          chk("rand_parity_en", 32'(parity_enable), 32'(it.pe));
          chk("rand_parity_type", 32'(parity_type), 32'(it.pt));
          chk("rand_req_ready", 32'(req_ready), 32'(exp_rdy));
          void'(rq[w].pop_front());
          exp_ptr = (w + 1) % N;
          sent++;
        end
      end else begin
        chk("rand_ready_quiet", 32'(req_ready), 32'h0);
      end
      prev_dv = Data_Valid;
      if (pushed < 80 && $urandom_range(0, 3) == 0) begin
        it.data = 8'($urandom);
        it.pe   = 1'($urandom);
        it.pt   = 1'($urandom);
        rq[$urandom_range(0, 3)].push_back(it);
        pushed++;
      end
      frame_len = int'($urandom_range(1, 6));
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0].data;
          req_pe[i]          = rq[i][0].pe;
          req_pt[i]          = rq[i][0].pt;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    chk("rand_all_sent", 32'(sent), 32'd80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
